secure_memory_bank: RTL

// - Avalon-MM slave word store behind the secure-memory custom instruction's master port.
// - Holds XOR-encrypted words and serves 1-cycle registered reads.
// - Provides hardware zeroize (automatic after reset, or on request) and sticky access-error flags.
// - The upstream master never retries on waitrequest, so any access during zeroize is dropped and flagged.

---
 rtl/secure_memory_bank.sv | 135 +++++++++++++
 1 files changed

// File: rtl/secure_memory_bank.sv
// Avalon-MM word store for the secure-memory custom instruction: byte-enabled writes,
// registered reads, hardware zeroize and sticky access-error flags.
module secure_memory_bank #(
  parameter int unsigned ADDR_W      = 10,
  parameter bit          WIPE_ON_RST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic [15:0] address,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        waitrequest,
  input  logic        zeroize,
  input  logic        err_clear,
  output logic        busy,
  output logic        wipe_done,
  output logic        oob_err,
  output logic        drop_err
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StClear = 1'b1;
  localparam logic [0:0] StReset = WIPE_ON_RST ? StClear : StIdle;

  localparam logic [ADDR_W-1:0] CntLast = {ADDR_W{1'b1}};

  logic [31:0] mem [Depth];

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [31:0]       readdata_q;
  logic              wipe_done_q, wipe_done_d;
  logic              oob_err_q, oob_err_d;
  logic              drop_err_q, drop_err_d;

  logic              in_idle, in_clear;
  logic              addr_oob, acc, acc_ok, drop;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;

  always_comb begin
    in_idle  = (state_q == StIdle);
    in_clear = (state_q == StClear);
    addr_oob = ((address >> ADDR_W) != 16'd0);
    acc      = chipselect & in_idle;
    acc_ok   = acc & ~addr_oob;
    drop     = chipselect & in_clear;
  end

  // Single write port: the wipe counter owns it in CLEAR, the bus in IDLE.
  always_comb begin
    mem_we    = ~reset & (in_clear | (acc_ok & write));
    mem_addr  = in_clear ? cnt_q : address[ADDR_W-1:0];
    mem_be    = in_clear ? 4'hF : byteenable;
    mem_wdata = in_clear ? 32'h0 : writedata;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wipe_done_d = 1'b0;
    if (in_idle) begin
      if (zeroize) begin
        state_d = StClear;
        cnt_d   = '0;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CntLast) begin
        state_d     = StIdle;
        wipe_done_d = 1'b1;
      end
    end
  end

  // A new error outranks err_clear in the same cycle.
  always_comb begin
    oob_err_d  = (acc & addr_oob) | (oob_err_q & ~err_clear);
    drop_err_d = drop | (drop_err_q & ~err_clear);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StReset;
      cnt_q       <= '0;
      wipe_done_q <= 1'b0;
      oob_err_q   <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wipe_done_q <= wipe_done_d;
      oob_err_q   <= oob_err_d;
      drop_err_q  <= drop_err_d;
    end
  end

  // Zeroize start overrides a read accepted in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_q <= 32'h0;
    end else if (in_idle && zeroize) begin
      readdata_q <= 32'h0;
    end else if (acc && !write) begin
      readdata_q <= addr_oob ? 32'h0 : mem[mem_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) begin
          mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    readdata    = readdata_q;
    waitrequest = in_clear;
    busy        = in_clear;
    wipe_done   = wipe_done_q;
    oob_err     = oob_err_q;
    drop_err    = drop_err_q;
  end

endmodule
